// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule block: FSM states, schedule limits
// and the combinational GF(2^8) helpers used by the round-key logic.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  localparam int LAST_IDX_128 = 10;
  localparam int LAST_IDX_256 = 14;
  localparam int AES_WORD     = 32;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as affine(x^254): inverse via the chain x^2 * x^4 * ... * x^128.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 2; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [AES_WORD-1:0] sub_word(input logic [AES_WORD-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [AES_WORD-1:0] rcon(input logic [3:0] rnum);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 10; i++) begin
      if (i < int'(rnum)) r = xtime(r);
    end
    return {r, 24'h000000};
  endfunction

endpackage

// File: rtl/generateKey.sv
// One key-expansion step: derives the next round key from the last one (or two,
// for AES-256) and advances the round counter/flip, with a one-cycle registered result.
module generateKey
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 validIn,
  input  logic                 wide,
  input  logic [3:0]           rnum,
  input  logic                 flip,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [KEY_WIDTH-1:0] prev_key,
  output logic                 validOut,
  output logic [KEY_WIDTH-1:0] outKey,
  output logic [3:0]           rnum_out,
  output logic                 outflip
);

  localparam int NW = KEY_WIDTH / AES_WORD;

  logic [AES_WORD-1:0]  last_w;
  logic [AES_WORD-1:0]  temp;
  logic [KEY_WIDTH-1:0] base;
  logic [KEY_WIDTH-1:0] next_key;

  assign last_w = key[AES_WORD-1:0];
  // flip=0 is the AES-256 half-step: SubWord only, no rotate and no round constant.
  assign temp   = flip ? (sub_word({last_w[23:0], last_w[31:24]}) ^ rcon(rnum))
                       : sub_word(last_w);
  assign base   = wide ? prev_key : key;

  always_comb begin
    logic [AES_WORD-1:0] w;
    w        = temp;
    next_key = '0;
    for (int i = 0; i < NW; i++) begin
      w = base[KEY_WIDTH-1-i*AES_WORD -: AES_WORD] ^ w;
      next_key[KEY_WIDTH-1-i*AES_WORD -: AES_WORD] = w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validOut <= 1'b0;
      outKey   <= '0;
      rnum_out <= '0;
      outflip  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      validOut <= validIn;
      if (validIn) begin
        outKey   <= next_key;
        rnum_out <= (wide && flip) ? rnum : rnum + 4'd1;
        outflip  <= wide ? ~flip : 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128/256 key-expansion sequencer: steps generateKey once per round,
// stores every round key and serves them through a registered read port.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH = 128,
  parameter int NUM_KEYS  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   keyLen,
  input  logic [2*KEY_WIDTH-1:0] key_in,
  output logic                   busy,
  output logic                   done,
  output logic                   keys_valid,
  input  logic [3:0]             rd_addr,
  output logic [KEY_WIDTH-1:0]   rd_key
);

  state_t               state;
  state_t               next_state;
  logic                 len_q;
  logic [3:0]           idx;
  logic [3:0]           rnum;
  logic                 flip;
  logic [3:0]           last_idx;
  logic [KEY_WIDTH-1:0] rk [NUM_KEYS];

  logic                 gk_valid;
  logic                 gk_vout;
  logic [KEY_WIDTH-1:0] gk_key;
  logic [KEY_WIDTH-1:0] gk_prev;
  logic [KEY_WIDTH-1:0] gk_out;
  logic [3:0]           gk_rnum;
  logic                 gk_flip;

  assign last_idx = len_q ? 4'(LAST_IDX_256) : 4'(LAST_IDX_128);
  assign gk_key   = (idx != 4'd0) ? rk[idx - 4'd1] : rk[0];
  assign gk_prev  = (idx >= 4'd2) ? rk[idx - 4'd2] : rk[0];

  generateKey #(.KEY_WIDTH(KEY_WIDTH)) u_gk (
    .clk      (clk),
    .reset    (reset),
    .validIn  (gk_valid),
    .wide     (len_q),
    .rnum     (rnum),
    .flip     (flip),
    .key      (gk_key),
    .prev_key (gk_prev),
    .validOut (gk_vout),
    .outKey   (gk_out),
    .rnum_out (gk_rnum),
    .outflip  (gk_flip)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    next_state = state;
    gk_valid   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = ISSUE;
      ISSUE: begin
        gk_valid   = 1'b1;
        next_state = CAPT;
      end
      CAPT:  if (gk_vout) next_state = (idx == last_idx) ? DONE : ISSUE;
      DONE:  begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the key store is a plain register array, so it is cleared on reset
      // like any other state; an aborted run can never leave stale keys readable.
      for (int i = 0; i < NUM_KEYS; i++) rk[i] <= '0;
      len_q      <= 1'b0;
      idx        <= '0;
      rnum       <= '0;
      flip       <= 1'b0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      rd_key     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_q <= keyLen;
          rk[0] <= key_in[2*KEY_WIDTH-1:KEY_WIDTH];
          if (keyLen) begin
            rk[1] <= key_in[KEY_WIDTH-1:0];
            idx   <= 4'd2;
          end else begin
            idx   <= 4'd1;
          end
          rnum       <= '0;
          flip       <= 1'b1;
          keys_valid <= 1'b0;
          busy       <= 1'b1;
        end
        CAPT: if (gk_vout) begin
          rk[idx] <= gk_out;
          rnum    <= gk_rnum;
          flip    <= gk_flip;
          idx     <= idx + 4'd1;
        end
        DONE: begin
          keys_valid <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
      rd_key <= (rd_addr <= last_idx) ? rk[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 key-expansion vectors,
// timing of done, start filtering, asynchronous reset abort and back-to-back runs.
module tb_key_schedule_ctrl;

  logic         clk;
  logic         reset;
  logic         start;
  logic         keyLen;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] K1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  key_schedule_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .keyLen     (keyLen),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_addr    (rd_addr),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary line");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_key(input logic [3:0] a, output logic [127:0] k);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    k = rd_key;
  endtask

  // Start a run and watch a fixed 40-edge window; extra start pulses carry a bogus key.
  task automatic run(input logic len, input logic [255:0] k, input int pa, input int pb,
                     output int first, output int cnt);
    @(negedge clk);
    keyLen = len;
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    first = -1;
    cnt   = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      start  = (e == pa) || (e == pb);
      key_in = start ? ~k : k;
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [127:0] k;
    int first, second, cnt;
    logic kv21, kv22, b22;

    reset   = 1'b0;
    start   = 1'b0;
    keyLen  = 1'b0;
    key_in  = '0;
    rd_addr = '0;
    #3;
    check("reset_busy",  128'(busy),       128'd0);
    check("reset_done",  128'(done),       128'd0);
    check("reset_kv",    128'(keys_valid), 128'd0);
    check("reset_rdkey", rd_key,           128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // AES-128, FIPS-197 C.1 key
    run(1'b0, K1, -1, -1, first, cnt);
    check("t1_done_edge", 128'(first), 128'd20);
    check("t1_done_cnt",  128'(cnt),   128'd1);
    check("t1_busy",      128'(busy),  128'd0);
    check("t1_kv",        128'(keys_valid), 128'd1);
    read_key(4'd0, k);  check("t1_rk0",  k, 128'h000102030405060708090a0b0c0d0e0f);
    read_key(4'd1, k);  check("t1_rk1",  k, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    read_key(4'd10, k); check("t1_rk10", k, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // AES-128, FIPS-197 A.1 key
    run(1'b0, K2, -1, -1, first, cnt);
    check("t2_done_edge", 128'(first), 128'd20);
    read_key(4'd1, k);  check("t2_rk1",  k, 128'ha0fafe1788542cb123a339392a6c7605);
    read_key(4'd10, k); check("t2_rk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_key(4'd11, k); check("t2_rk11_oob", k, 128'd0);

    // AES-256, FIPS-197 C.3 key
    run(1'b1, K3, -1, -1, first, cnt);
    check("t3_done_edge", 128'(first), 128'd26);
    check("t3_done_cnt",  128'(cnt),   128'd1);
    read_key(4'd1, k);  check("t3_rk1",  k, 128'h101112131415161718191a1b1c1d1e1f);
    read_key(4'd2, k);  check("t3_rk2",  k, 128'ha573c29fa176c498a97fce93a572c09c);
    read_key(4'd14, k); check("t3_rk14", k, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    read_key(4'd15, k); check("t3_rk15_oob", k, 128'd0);

    // start pulses during a run are ignored
    run(1'b0, K1, 3, 9, first, cnt);
    check("t4_done_edge", 128'(first), 128'd20);
    check("t4_done_cnt",  128'(cnt),   128'd1);
    read_key(4'd1, k);  check("t4_rk1",  k, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    read_key(4'd10, k); check("t4_rk10", k, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // asynchronous reset aborts a run mid-way
    @(negedge clk);
    keyLen = 1'b0;
    key_in = K2;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_busy",  128'(busy),       128'd0);
    check("t5_kv",    128'(keys_valid), 128'd0);
    check("t5_rdkey", rd_key,           128'd0);
    @(negedge clk);
    reset = 1'b1;
    read_key(4'd0, k);  check("t5_rk0_clr", k, 128'd0);
    run(1'b0, K2, -1, -1, first, cnt);
    check("t5_done_edge", 128'(first), 128'd20);
    read_key(4'd10, k); check("t5_rk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // back-to-back: 128 then 256 with start held high
    @(negedge clk);
    keyLen = 1'b0;
    key_in = K1;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    keyLen = 1'b1;
    key_in = K3;
    first  = -1;
    second = -1;
    cnt    = 0;
    kv21   = 1'b0;
    kv22   = 1'b1;
    b22    = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (e == 21) kv21 = keys_valid;
      if (e == 22) begin
        kv22 = keys_valid;
        b22  = busy;
      end
      if (done) begin
        cnt++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      @(negedge clk);
      if (e == 22) start = 1'b0;
    end
    check("t6_first_done",  128'(first),  128'd20);
    check("t6_second_done", 128'(second), 128'd48);
    check("t6_done_cnt",    128'(cnt),    128'd2);
    check("t6_kv_after1",   128'(kv21),   128'd1);
    check("t6_kv_drop",     128'(kv22),   128'd0);
    check("t6_busy2",       128'(b22),    128'd1);
    read_key(4'd1, k);  check("t6_rk1",  k, 128'h101112131415161718191a1b1c1d1e1f);
    read_key(4'd14, k); check("t6_rk14", k, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("t6_kv_end", 128'(keys_valid), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
